// File: rtl/lvda_discrete_latch_bank.sv
// Address-decoded bank of discrete latches for the LVDA: each channel is either
// V1-held (set/hold/drop) or self-timed (fixed number of PULSE_TICK periods).
module lvda_discrete_latch_bank #(
  parameter int unsigned NUM_CH     = 8,
  parameter int unsigned ADDR_W     = 5,
  parameter int unsigned BASE_ADDR  = 4,
  parameter logic [31:0] PULSE_MASK = 32'h0000_00C0,
  parameter int unsigned PULSE_LEN  = 4
) (
  input  logic              SIM_CLK,
  input  logic              SIM_RST,
  input  logic              V1,
  input  logic              STROBE,
  input  logic              QUAL,
  input  logic [ADDR_W-1:0] ADDR,
  input  logic              CLR,
  input  logic              PULSE_TICK,
  output logic [NUM_CH-1:0] Q,
  output logic [NUM_CH-1:0] QN,
  output logic              HIT,
  output logic              MISS
);

  // Guard keeps the counter at least one bit wide even for a rejected PULSE_LEN.
  localparam int unsigned CNT_W = (PULSE_LEN < 1) ? 1 : $clog2(PULSE_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(PULSE_LEN);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Elaboration-time parameter sanity checks.
  generate
    if (NUM_CH < 1 || NUM_CH > 32) begin : g_bad_num_ch
      $error("lvda_discrete_latch_bank: NUM_CH must be 1..32");
    end
    if (64'(BASE_ADDR) + 64'(NUM_CH) - 64'(1) >= (64'(1) << ADDR_W)) begin : g_bad_addr
      $error("lvda_discrete_latch_bank: channel address range exceeds ADDR_W");
    end
    if (PULSE_LEN < 1) begin : g_bad_len
      $error("lvda_discrete_latch_bank: PULSE_LEN must be >= 1");
    end
  endgenerate

  logic [NUM_CH-1:0] set;
  logic [NUM_CH-1:0] q_nxt;
  logic [CNT_W-1:0]  cnt     [NUM_CH];
  logic [CNT_W-1:0]  cnt_nxt [NUM_CH];
  logic              qualified;
  logic              any_set;

  // Qualified strobe decode; channel addresses never wrap (checked above).
  always_comb begin : decode
    set       = '0;
    qualified = STROBE & QUAL;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      set[i] = qualified & (ADDR == ADDR_W'(BASE_ADDR + i));
    end
    any_set = |set;
  end

  // Per-channel next state: set dominates clear, V1 drop and tick.
  always_comb begin : next_state
    q_nxt   = Q;
    cnt_nxt = cnt;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (PULSE_MASK[i]) begin
        if (set[i]) begin
          q_nxt[i]   = 1'b1;
          cnt_nxt[i] = CNT_LOAD;
        end else if (CLR) begin
          q_nxt[i]   = 1'b0;
          cnt_nxt[i] = '0;
        end else if (PULSE_TICK && Q[i]) begin
          cnt_nxt[i] = cnt[i] - CNT_ONE;
          if (cnt[i] == CNT_ONE) begin
            q_nxt[i] = 1'b0;
          end
        end
      end else begin
        q_nxt[i]   = set[i] | (Q[i] & V1 & ~CLR);
        cnt_nxt[i] = '0;
      end
    end
  end

  // State register; synchronous reset overrides everything.
  always_ff @(posedge SIM_CLK) begin
    if (SIM_RST) begin
      Q    <= '0;
      HIT  <= 1'b0;
      MISS <= 1'b0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      Q    <= q_nxt;
      HIT  <= any_set;
      MISS <= qualified & ~any_set;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        cnt[i] <= cnt_nxt[i];
      end
    end
  end

  assign QN = ~Q;

endmodule

// File: tb/tb_lvda_discrete_latch_bank.sv
// Directed self-checking bench for lvda_discrete_latch_bank (default parameters).
module tb_lvda_discrete_latch_bank;

  logic       SIM_CLK;
  logic       SIM_RST;
  logic       V1;
  logic       STROBE;
  logic       QUAL;
  logic [4:0] ADDR;
  logic       CLR;
  logic       PULSE_TICK;
  logic [7:0] Q;
  logic [7:0] QN;
  logic       HIT;
  logic       MISS;

  int n_checks = 0;
  int n_fail   = 0;

  lvda_discrete_latch_bank dut (
    .SIM_CLK    (SIM_CLK),
    .SIM_RST    (SIM_RST),
    .V1         (V1),
    .STROBE     (STROBE),
    .QUAL       (QUAL),
    .ADDR       (ADDR),
    .CLR        (CLR),
    .PULSE_TICK (PULSE_TICK),
    .Q          (Q),
    .QN         (QN),
    .HIT        (HIT),
    .MISS       (MISS)
  );

  initial SIM_CLK = 1'b0;
  always #5 SIM_CLK = ~SIM_CLK;

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic step();
    @(posedge SIM_CLK);
    #1;
  endtask

  task automatic idle_inputs();
    STROBE = 1'b0; QUAL = 1'b0; ADDR = 5'd0; CLR = 1'b0; PULSE_TICK = 1'b0;
  endtask

  task automatic strobe_addr(input logic [4:0] a);
    STROBE = 1'b1; QUAL = 1'b1; ADDR = a;
  endtask

  task automatic test_reset();
    SIM_RST = 1'b1;
    for (int i = 0; i < 2; i++) begin
      V1 = 1'($urandom); STROBE = 1'($urandom); QUAL = 1'($urandom);
      ADDR = 5'($urandom); CLR = 1'($urandom); PULSE_TICK = 1'($urandom);
      step();
    end
    n_checks++; if (Q !== 8'h00) begin n_fail++; $display("FAIL reset_q got %h want %h", Q, 8'h00); end
    n_checks++; if (QN !== 8'hFF) begin n_fail++; $display("FAIL reset_qn got %h want %h", QN, 8'hFF); end
    n_checks++; if (HIT !== 1'b0) begin n_fail++; $display("FAIL reset_hit got %b want 0", HIT); end
    n_checks++; if (MISS !== 1'b0) begin n_fail++; $display("FAIL reset_miss got %b want 0", MISS); end
    SIM_RST = 1'b0;
    V1 = 1'b1;
    idle_inputs();
    step();
    n_checks++; if (Q !== 8'h00) begin n_fail++; $display("FAIL reset_release_q got %h want %h", Q, 8'h00); end
  endtask

  task automatic test_held();
    V1 = 1'b1;
    strobe_addr(5'd5);
    step();
    idle_inputs();
    n_checks++; if (Q !== 8'h02) begin n_fail++; $display("FAIL held_set_q got %h want %h", Q, 8'h02); end
    n_checks++; if (QN !== 8'hFD) begin n_fail++; $display("FAIL held_set_qn got %h want %h", QN, 8'hFD); end
    n_checks++; if (HIT !== 1'b1) begin n_fail++; $display("FAIL held_set_hit got %b want 1", HIT); end
    n_checks++; if (MISS !== 1'b0) begin n_fail++; $display("FAIL held_set_miss got %b want 0", MISS); end
    for (int i = 0; i < 10; i++) step();
    n_checks++; if (Q !== 8'h02) begin n_fail++; $display("FAIL held_hold_q got %h want %h", Q, 8'h02); end
    n_checks++; if (HIT !== 1'b0) begin n_fail++; $display("FAIL held_hit_pulse got %b want 0", HIT); end
    V1 = 1'b0;
    step();
    V1 = 1'b1;
    n_checks++; if (Q !== 8'h00) begin n_fail++; $display("FAIL held_drop_q got %h want %h", Q, 8'h00); end
  endtask

  task automatic test_set_vs_clear();
    V1 = 1'b1;
    strobe_addr(5'd4);
    step();
    idle_inputs();
    step();
    n_checks++; if (Q !== 8'h01) begin n_fail++; $display("FAIL svc_hold_q got %h want %h", Q, 8'h01); end
    strobe_addr(5'd4);
    CLR = 1'b1;
    step();
    n_checks++; if (Q !== 8'h01) begin n_fail++; $display("FAIL svc_set_wins_q got %h want %h", Q, 8'h01); end
    STROBE = 1'b0; QUAL = 1'b0;
    step();
    CLR = 1'b0;
    n_checks++; if (Q !== 8'h00) begin n_fail++; $display("FAIL svc_clear_q got %h want %h", Q, 8'h00); end
    // Set beats V1=0 in the same cycle.
    V1 = 1'b0;
    strobe_addr(5'd4);
    step();
    idle_inputs();
    n_checks++; if (Q !== 8'h01) begin n_fail++; $display("FAIL svc_set_over_v1_q got %h want %h", Q, 8'h01); end
    step();
    n_checks++; if (Q !== 8'h00) begin n_fail++; $display("FAIL svc_v1_drop_q got %h want %h", Q, 8'h00); end
    V1 = 1'b1;
  endtask

  task automatic test_timed();
    logic e;
    V1 = 1'b0;
    strobe_addr(5'd10);
    step();
    idle_inputs();
    n_checks++; if (Q !== 8'h40) begin n_fail++; $display("FAIL timed_set_q got %h want %h", Q, 8'h40); end
    n_checks++; if (HIT !== 1'b1) begin n_fail++; $display("FAIL timed_set_hit got %b want 1", HIT); end
    for (int k = 1; k <= 4; k++) begin
      step(); step();
      n_checks++; if (Q[6] !== 1'b1) begin n_fail++; $display("FAIL timed_between_ticks k=%0d got %b want 1", k, Q[6]); end
      PULSE_TICK = 1'b1;
      step();
      PULSE_TICK = 1'b0;
      e = (k < 4);
      n_checks++; if (Q[6] !== e) begin n_fail++; $display("FAIL timed_tick k=%0d got %b want %b", k, Q[6], e); end
    end
    for (int i = 0; i < 4; i++) begin
      PULSE_TICK = 1'(i % 2);
      step();
    end
    PULSE_TICK = 1'b0;
    n_checks++; if (Q !== 8'h00) begin n_fail++; $display("FAIL timed_no_residual got %h want %h", Q, 8'h00); end

    // Retrigger after two ticks; the coincident tick must not count.
    strobe_addr(5'd10);
    step();
    idle_inputs();
    for (int k = 1; k <= 2; k++) begin
      step();
      PULSE_TICK = 1'b1;
      step();
      PULSE_TICK = 1'b0;
    end
    n_checks++; if (Q[6] !== 1'b1) begin n_fail++; $display("FAIL retrig_pre got %b want 1", Q[6]); end
    strobe_addr(5'd10);
    PULSE_TICK = 1'b1;
    step();
    idle_inputs();
    n_checks++; if (Q[6] !== 1'b1) begin n_fail++; $display("FAIL retrig_reload got %b want 1", Q[6]); end
    for (int k = 1; k <= 4; k++) begin
      step();
      PULSE_TICK = 1'b1;
      step();
      PULSE_TICK = 1'b0;
      e = (k < 4);
      n_checks++; if (Q[6] !== e) begin n_fail++; $display("FAIL retrig_tick k=%0d got %b want %b", k, Q[6], e); end
    end
    V1 = 1'b1;
  endtask

  task automatic test_miss();
    V1 = 1'b1;
    strobe_addr(5'd4);
    step();
    strobe_addr(5'd3);
    step();
    n_checks++; if (Q !== 8'h01) begin n_fail++; $display("FAIL miss_low_q got %h want %h", Q, 8'h01); end
    n_checks++; if (MISS !== 1'b1) begin n_fail++; $display("FAIL miss_low_miss got %b want 1", MISS); end
    n_checks++; if (HIT !== 1'b0) begin n_fail++; $display("FAIL miss_low_hit got %b want 0", HIT); end
    strobe_addr(5'd12);
    step();
    n_checks++; if (Q !== 8'h01) begin n_fail++; $display("FAIL miss_high_q got %h want %h", Q, 8'h01); end
    n_checks++; if (MISS !== 1'b1) begin n_fail++; $display("FAIL miss_high_miss got %b want 1", MISS); end
    strobe_addr(5'd11);
    step();
    n_checks++; if (Q !== 8'h81) begin n_fail++; $display("FAIL miss_top_q got %h want %h", Q, 8'h81); end
    n_checks++; if (HIT !== 1'b1) begin n_fail++; $display("FAIL miss_top_hit got %b want 1", HIT); end
    n_checks++; if (MISS !== 1'b0) begin n_fail++; $display("FAIL miss_top_miss got %b want 0", MISS); end
    STROBE = 1'b1; QUAL = 1'b0; ADDR = 5'd5;
    step();
    n_checks++; if (MISS !== 1'b0) begin n_fail++; $display("FAIL noqual_miss got %b want 0", MISS); end
    n_checks++; if (HIT !== 1'b0) begin n_fail++; $display("FAIL noqual_hit got %b want 0", HIT); end
    n_checks++; if (Q !== 8'h81) begin n_fail++; $display("FAIL noqual_q got %h want %h", Q, 8'h81); end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    V1 = 1'b1;
    CLR = 1'b1;
    step();
    CLR = 1'b0;
    n_checks++; if (Q !== 8'h00) begin n_fail++; $display("FAIL mid_clr_q got %h want %h", Q, 8'h00); end
    strobe_addr(5'd11); step();
    strobe_addr(5'd10); step();
    idle_inputs();
    PULSE_TICK = 1'b1; step(); step();
    PULSE_TICK = 1'b0;
    strobe_addr(5'd4); step();
    strobe_addr(5'd5); step();
    idle_inputs();
    n_checks++; if (Q !== 8'hC3) begin n_fail++; $display("FAIL mid_build_q got %h want %h", Q, 8'hC3); end
    SIM_RST = 1'b1;
    step();
    SIM_RST = 1'b0;
    n_checks++; if (Q !== 8'h00) begin n_fail++; $display("FAIL mid_reset_q got %h want %h", Q, 8'h00); end
    n_checks++; if (QN !== 8'hFF) begin n_fail++; $display("FAIL mid_reset_qn got %h want %h", QN, 8'hFF); end
    for (int i = 0; i < 12; i++) begin
      PULSE_TICK = 1'(i % 2);
      step();
      n_checks++; if (Q !== 8'h00) begin n_fail++; $display("FAIL mid_after_reset cyc=%0d got %h want %h", i, Q, 8'h00); end
    end
    PULSE_TICK = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_q;
    V1 = 1'b1;
    exp_q = 8'h00;
    for (int i = 0; i < 4; i++) begin
      strobe_addr(5'(4 + i));
      step();
      exp_q = exp_q | 8'(1 << i);
      n_checks++; if (Q !== exp_q) begin n_fail++; $display("FAIL b2b_q i=%0d got %h want %h", i, Q, exp_q); end
      n_checks++; if (HIT !== 1'b1) begin n_fail++; $display("FAIL b2b_hit i=%0d got %b want 1", i, HIT); end
    end
    idle_inputs();
    step();
    n_checks++; if (HIT !== 1'b0) begin n_fail++; $display("FAIL b2b_hit_end got %b want 0", HIT); end
    n_checks++; if (Q !== 8'h0F) begin n_fail++; $display("FAIL b2b_q_end got %h want %h", Q, 8'h0F); end
  endtask

  initial begin
    SIM_RST = 1'b1;
    V1 = 1'b0;
    idle_inputs();
    test_reset();
    test_held();
    test_set_vs_clear();
    test_timed();
    test_miss();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
